// File: rtl/lzc_normalizer_pipe.sv
// Two-stage leading-zero / leading-one counter with left-normalisation.
// Stage 1 registers the operand, its count and the zero flag.
// Stage 2 registers the count and the normalised mantissa.
// Handshake: valid/ready with a single global stall. Both stages hold
// whenever stage 2 has a result that downstream has not taken.
module lzc_normalizer_pipe #(
    parameter int  in_width  = 32,
    localparam int cnt_width = $clog2(2**$clog2(in_width) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [in_width-1:0]  Di,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [cnt_width-1:0] Do,
    output logic [in_width-1:0]  Dnorm,
    output logic                 zero
);

    logic                 advance;
    logic [in_width-1:0]  op;
    logic [cnt_width-1:0] cnt;

    logic                 s1_valid;
    logic [in_width-1:0]  s1_data;
    logic [cnt_width-1:0] s1_cnt;
    logic                 s1_zero;

    // An empty stage 2 always advances, so bubbles collapse even when
    // downstream is not ready.
    assign advance  = ~(out_valid & ~out_ready);
    assign in_ready = advance;

    // Leading-ones mode is counted as leading zeros of the inverted operand.
    assign op = mode ? ~Di : Di;

    // Priority scan: the highest set bit wins. With no set bit the count
    // saturates at in_width, as if the operand were padded below with 1s.
    always_comb begin
        cnt = cnt_width'(in_width);
        for (int i = 0; i < in_width; i++) begin
            if (op[i]) begin
                cnt = cnt_width'(in_width - 1 - i);
            end
        end
    end

    // Stage 1: capture the original operand (not op) plus count and zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cnt   <= '0;
            s1_zero  <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= Di;
                s1_cnt  <= cnt;
                s1_zero <= (cnt == cnt_width'(in_width));
            end
        end
    end

    // Stage 2: normalise. A zero operand yields zero in both modes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Do        <= '0;
            Dnorm     <= '0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Do    <= s1_cnt;
                Dnorm <= s1_zero ? '0 : (s1_data << s1_cnt);
                zero  <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_lzc_normalizer_pipe.sv
module tb_lzc_normalizer_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic        iv32 = 1'b0, m32 = 1'b0, or32 = 1'b1;
    logic        ir32, ov32, z32;
    logic [31:0] d32 = '0, n32;
    logic [5:0]  c32;

    logic        iv24 = 1'b0, m24 = 1'b0, or24 = 1'b1;
    logic        ir24, ov24, z24;
    logic [23:0] d24 = '0, n24;
    logic [5:0]  c24;

    lzc_normalizer_pipe #(.in_width(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .Di(d32), .mode(m32),
        .out_valid(ov32), .out_ready(or32), .Do(c32), .Dnorm(n32), .zero(z32)
    );

    lzc_normalizer_pipe #(.in_width(24)) dut24 (
        .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .Di(d24), .mode(m24),
        .out_valid(ov24), .out_ready(or24), .Do(c24), .Dnorm(n24), .zero(z24)
    );

    typedef struct packed {
        logic [5:0]  cnt;
        logic [31:0] norm;
        logic        zero;
    } exp_t;

    exp_t q32[$];
    exp_t q24[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   nout32      = 0;

    // Reference: walk MSB-first, stop at the first terminating bit.
    function automatic exp_t model(input logic [31:0] d, input logic m, input int w);
        exp_t        e;
        int          c    = 0;
        bit          done = 1'b0;
        logic [31:0] mask;
        for (int i = w - 1; i >= 0; i--) begin
            if (!done) begin
                if ((d[i] ^ m) == 1'b1) done = 1'b1;
                else c++;
            end
        end
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        e.cnt  = 6'(c);
        e.zero = (c == w);
        e.norm = e.zero ? 32'd0 : ((d << c) & mask);
        return e;
    endfunction

    // Scoreboard for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (ir32 !== !(ov32 && !or32)) begin
                miscompares++;
                $display("FAIL in_ready32: got %b, want %b (out_valid=%b out_ready=%b)",
                         ir32, !(ov32 && !or32), ov32, or32);
            end
            if (ov32) begin
                vectors++;
                if (q32.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious32: got out_valid=1 Do=%0d Dnorm=%h, want no output",
                             c32, n32);
                end else begin
                    if (c32 !== q32[0].cnt || n32 !== q32[0].norm || z32 !== q32[0].zero) begin
                        miscompares++;
                        $display("FAIL result32: got Do=%0d Dnorm=%h zero=%b, want Do=%0d Dnorm=%h zero=%b",
                                 c32, n32, z32, q32[0].cnt, q32[0].norm, q32[0].zero);
                    end
                    if (or32) begin
                        void'(q32.pop_front());
                        nout32++;
                    end
                end
            end
            if (iv32 && ir32) q32.push_back(model(d32, m32, 32));
        end
    end

    // Scoreboard for the 24-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (ov24) begin
                vectors++;
                if (q24.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious24: got out_valid=1 Do=%0d, want no output", c24);
                end else begin
                    if (c24 !== q24[0].cnt || n24 !== q24[0].norm[23:0] || z24 !== q24[0].zero) begin
                        miscompares++;
                        $display("FAIL result24: got Do=%0d Dnorm=%h zero=%b, want Do=%0d Dnorm=%h zero=%b",
                                 c24, n24, z24, q24[0].cnt, q24[0].norm[23:0], q24[0].zero);
                    end
                    if (or24) void'(q24.pop_front());
                end
            end
            if (iv24 && ir24) q24.push_back(model({8'd0, d24}, m24, 24));
        end
    end

    // All drivers start and end at posedge+1.
    task automatic send32(input logic [31:0] d, input logic m);
        int k = 0;
        iv32 = 1'b1; d32 = d; m32 = m;
        @(negedge clk);
        while (!ir32 && k < 100) begin
            k++;
            @(negedge clk);
        end
        vectors++;
        if (!ir32) begin
            miscompares++;
            $display("FAIL accept32: got in_ready=0 for 100 cycles, want 1");
        end
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic send24(input logic [23:0] d, input logic m);
        int k = 0;
        iv24 = 1'b1; d24 = d; m24 = m;
        @(negedge clk);
        while (!ir24 && k < 100) begin
            k++;
            @(negedge clk);
        end
        vectors++;
        if (!ir24) begin
            miscompares++;
            $display("FAIL accept24: got in_ready=0 for 100 cycles, want 1");
        end
        @(posedge clk); #1;
        iv24 = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((q32.size() != 0 || q24.size() != 0) && k < 100) begin
            k++;
            @(posedge clk); #1;
        end
        vectors++;
        if (q32.size() != 0 || q24.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: got %0d/%0d results outstanding, want 0/0",
                     name, q32.size(), q24.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv32 = 1'b0; iv24 = 1'b0; or32 = 1'b1; or24 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b0 || c32 !== 6'd0 || n32 !== 32'd0 || z32 !== 1'b0 || ir32 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset32: got ov=%b Do=%0d Dnorm=%h zero=%b in_ready=%b, want 0 0 0 0 1",
                     ov32, c32, n32, z32, ir32);
        end
        vectors++;
        if (ov24 !== 1'b0 || c24 !== 6'd0 || n24 !== 24'd0 || z24 !== 1'b0 || ir24 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset24: got ov=%b Do=%0d Dnorm=%h zero=%b in_ready=%b, want 0 0 0 0 1",
                     ov24, c24, n24, z24, ir24);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        or32 = 1'b1; iv32 = 1'b1; d32 = 32'h0001_0000; m32 = 1'b0;
        @(negedge clk);
        vectors++;
        if (ir32 !== 1'b1) begin
            miscompares++;
            $display("FAIL lat_accept: got in_ready=%b, want 1", ir32);
        end
        @(posedge clk); #1 iv32 = 1'b0;
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_early: got out_valid=%b after 1 cycle, want 0", ov32);
        end
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b1 || c32 !== 6'd15 || n32 !== 32'h8000_0000 || z32 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_result: got ov=%b Do=%0d Dnorm=%h zero=%b, want 1 15 80000000 0",
                     ov32, c32, n32, z32);
        end
        @(posedge clk); #1;
        drain("latency");
    endtask

    task automatic test_directed32();
        logic [31:0] d;
        send32(32'h0000_0000, 1'b0);
        send32(32'h8000_0001, 1'b0);
        send32(32'hFFF0_1234, 1'b1);
        send32(32'hFFFF_FFFF, 1'b1);
        send32(32'h0000_0000, 1'b1);
        send32(32'h0000_0001, 1'b0);
        send32(32'h7FFF_FFFF, 1'b1);
        for (int i = 0; i < 24; i++) begin
            d = $urandom >> $urandom_range(0, 31);
            if (i % 2 == 1) d = ~d;
            send32(d, 1'(i % 2));
        end
        drain("directed32");
    endtask

    task automatic test_back_to_back();
        bit         done = 1'b0;
        int         start = nout32;
        logic [3:0] pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 8; i++) send32(32'h0100_0000 >> (i * 3), 1'b0);
                done = 1'b1;
            end
            begin
                for (int cyc = 0; cyc < 300 && !(done && q32.size() == 0); cyc++) begin
                    or32 = pat[cyc % 4];
                    @(posedge clk); #1;
                end
            end
        join
        or32 = 1'b1;
        vectors++;
        if (nout32 - start != 8 || q32.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results (%0d outstanding), want 8 (0)",
                     nout32 - start, q32.size());
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        or32 = 1'b0;
        send32(32'h0000_00F0, 1'b0);
        send32(32'hF000_0000, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q32.delete();
        or32 = 1'b1;
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst: got out_valid=%b in_ready=%b, want 0 1", ov32, ir32);
        end
        @(posedge clk); #1;
        e = model(32'h0003_0000, 1'b0, 32);
        iv32 = 1'b1; d32 = 32'h0003_0000; m32 = 1'b0;
        @(posedge clk); #1 iv32 = 1'b0;
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_stale: got out_valid=%b 1 cycle after accept, want 0", ov32);
        end
        @(negedge clk);
        vectors++;
        if (ov32 !== 1'b1 || c32 !== e.cnt || n32 !== e.norm) begin
            miscompares++;
            $display("FAIL midrst_result: got ov=%b Do=%0d Dnorm=%h, want 1 %0d %h",
                     ov32, c32, n32, e.cnt, e.norm);
        end
        @(posedge clk); #1;
        drain("midreset");
    endtask

    task automatic test_w24();
        send24(24'h00_0001, 1'b0);
        send24(24'h00_0000, 1'b0);
        send24(24'hFF_FFFF, 1'b1);
        send24(24'h80_0000, 1'b0);
        send24(24'hF0_000F, 1'b1);
        for (int i = 0; i < 10; i++) send24(24'($urandom >> $urandom_range(8, 31)), 1'b0);
        drain("w24");
        vectors++;
        if (model(32'd0, 1'b0, 24).cnt !== 6'd24 || model(32'h1, 1'b0, 24).norm !== 32'h80_0000) begin
            miscompares++;
            $display("FAIL w24_model: reference count/norm for width 24 wrong");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_directed32();
        test_back_to_back();
        test_reset_midstream();
        test_w24();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lzc_normalizer_pipe.md
Name: lzc_normalizer_pipe

Overview:
- Two-stage pipelined leading-zero/leading-one counter with an integrated left-normalisation shifter.
- Used in the FPU after add/sub and multiply to produce the shift amount and the normalised mantissa in one block.
- Uses a valid/ready handshake with full backpressure, so it can sit between stalling pipeline stages.
- Generalises the combinational leading-zeros counter to arbitrary width, adds a leading-ones mode, a zero flag and registered timing.

Parameters:
- in_width, 32, data width in bits; legal for any in_width >= 4, power of two not required.
- cnt_width, $clog2(2**$clog2(in_width)+1), derived (localparam), count output width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  block can accept data this cycle.
- Di  input  in_width  operand.
- mode  input  1  0 = count leading zeros; 1 = count leading ones. Sampled with Di.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- Do  output  cnt_width  leading zero or one count, MSB-first.
- Dnorm  output  in_width  Di shifted left by Do, zero-filled.
- zero  output  1  operand had no terminating bit.

Behaviour:
- Reset:
  - One clock cycle with rst=1 clears both stage valid bits.
  - out_valid=0, Do=0, Dnorm=0, zero=0.
  - in_ready=1 in the cycle after reset is released.
  - Reset asserted mid-operation discards all in-flight data; no partial results are emitted.
- Handshake:
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - in_ready = ~(out_valid & ~out_ready). This is a global stall: both stages hold when stage 2 is full and not accepted.
  - Bubbles collapse. An empty stage 2 accepts from stage 1 even when out_ready=0.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - in_valid=0 inserts a bubble; no output is produced for it.
- Stage 1 (registered on input transfer):
  - Operand op = mode ? ~Di : Di, MSB first.
  - Count c = number of consecutive 0 bits of op from bit in_width-1 downward, range 0..in_width.
  - For non-power-of-two widths the operand is padded internally below the LSB with 1s, so c saturates at in_width, never at the padded width.
  - zero = (c == in_width).
  - Registers: Di, c, zero, valid.
- Stage 2 (registered on advance):
  - Dnorm = Di << c, shifting in zeros.
  - The original Di is shifted, not op, so leading-ones mode shifts out the ones.
  - When zero=1, Dnorm = 0 in both modes.
  - Do = c; zero passes through.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 result per cycle when out_ready=1.
- Ordering: results exit in input order. No drops and no duplicates under any out_ready pattern.
- Simultaneous events: input transfer and output transfer in the same cycle is legal. The pipeline advances and the new item enters stage 1.
- Widths: Do is zero-extended to cnt_width. For in_width=32, cnt_width=6; for in_width=24, cnt_width=6.

Test Plan:
- in_width=32, mode=0, Di=0x0001_0000, out_ready=1 -> 2 cycles later out_valid=1, Do=15, Dnorm=0x8000_0000, zero=0.
- in_width=32, mode=0, Di=0x0000_0000 -> Do=32, Dnorm=0, zero=1. Di=0x8000_0001 -> Do=0, Dnorm=0x8000_0001.
- in_width=32, mode=1:
  - Di=0xFFF0_1234 -> Do=12, Dnorm=0x0123_4000.
  - Di=0xFFFF_FFFF -> Do=32, zero=1, Dnorm=0.
- in_width=24, mode=0:
  - Di=0x00_0001 -> Do=23, Dnorm=0x80_0000.
  - Di=0 -> Do=24 (not 32), zero=1.
- Backpressure:
  - Stream of 8 back-to-back operands with out_ready toggling 1,0,0,1,... -> all 8 results appear in order, none lost or duplicated.
  - in_ready=0 exactly in cycles where out_valid=1 and out_ready=0.
  - Outputs hold stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1; a new operand returns its result 2 cycles after acceptance and no stale data is emitted.
